// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: stalls, flushes, memory holds and statistics.
// Optional operand forwarding is compiled in with `define HAZARD_FWD_EN.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clkIn,
    input  logic             resetIn,
    input  logic [4:0]       rs1In,
    input  logic [4:0]       rs2In,
    input  logic             useRs1In,
    input  logic             useRs2In,
    input  logic [4:0]       exRdIn,
    input  logic             exRegWriteIn,
    input  logic             exMemReadIn,
    input  logic [4:0]       maRdIn,
    input  logic             maRegWriteIn,
    input  logic             branchTakenIn,
    input  logic             memReadyIn,
    output logic             pcWriteOut,
    output logic             ifidWriteOut,
    output logic             ifidFlushOut,
    output logic             idexBubbleOut,
    output logic             pipeHoldOut,
    output logic [1:0]       fwdAOut,
    output logic [1:0]       fwdBOut,
    output logic [CNT_W-1:0] stallCntOut,
    output logic [CNT_W-1:0] flushCntOut,
    output logic [1:0]       stateOut
);

    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEMWAIT = 2'd2} state_t;

    state_t     state_r, saved_r, eff_state, nxt_state, nxt_saved;
    logic [1:0] stall_ctr_r, nxt_ctr;
    logic       stall_inc, flush_inc;
    logic       ex_m1, ex_m2, ma_m1, ma_m2, haz_ex, haz_ma;
    logic       stall_req, stall_two;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign ex_m1  = exRegWriteIn && (exRdIn != 5'd0) && useRs1In && (rs1In == exRdIn);
    assign ex_m2  = exRegWriteIn && (exRdIn != 5'd0) && useRs2In && (rs2In == exRdIn);
    assign ma_m1  = maRegWriteIn && (maRdIn != 5'd0) && useRs1In && (rs1In == maRdIn);
    assign ma_m2  = maRegWriteIn && (maRdIn != 5'd0) && useRs2In && (rs2In == maRdIn);
    assign haz_ex = ex_m1 || ex_m2;
    assign haz_ma = ma_m1 || ma_m2;

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    assign stall_req = haz_ex && exMemReadIn;
    assign stall_two = 1'b0;
    assign fwd_a = (ex_m1 && !exMemReadIn) ? 2'b01 : (ma_m1 ? 2'b10 : 2'b00);
    assign fwd_b = (ex_m2 && !exMemReadIn) ? 2'b01 : (ma_m2 ? 2'b10 : 2'b00);
`else
    logic unused_mem_read;
    assign unused_mem_read = exMemReadIn;
    assign stall_req = haz_ex || haz_ma;
    assign stall_two = haz_ex;
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
`endif

    assign fwdAOut   = resetIn ? 2'b00 : fwd_a;
    assign fwdBOut   = resetIn ? 2'b00 : fwd_b;
    assign eff_state = (state_r == MEMWAIT) ? saved_r : state_r;
    assign stateOut  = state_r;

    always_comb begin
        pcWriteOut    = 1'b1;
        ifidWriteOut  = 1'b1;
        ifidFlushOut  = 1'b0;
        idexBubbleOut = 1'b0;
        pipeHoldOut   = 1'b0;
        nxt_state     = eff_state;
        nxt_saved     = saved_r;
        nxt_ctr       = stall_ctr_r;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (resetIn) begin
            pcWriteOut    = 1'b0;
            ifidWriteOut  = 1'b0;
            ifidFlushOut  = 1'b1;
            idexBubbleOut = 1'b1;
        end else if (!memReadyIn) begin
            pcWriteOut   = 1'b0;
            ifidWriteOut = 1'b0;
            pipeHoldOut  = 1'b1;
            nxt_state    = MEMWAIT;
            if (state_r != MEMWAIT) nxt_saved = state_r;
        end else if (branchTakenIn) begin
            ifidFlushOut  = 1'b1;
            idexBubbleOut = 1'b1;
            nxt_ctr       = 2'd0;
            nxt_state     = RUN;
            flush_inc     = 1'b1;
        end else if (eff_state == STALL) begin
            pcWriteOut    = 1'b0;
            ifidWriteOut  = 1'b0;
            idexBubbleOut = 1'b1;
            stall_inc     = 1'b1;
            nxt_ctr       = (stall_ctr_r != 2'd0) ? stall_ctr_r - 2'd1 : 2'd0;
            nxt_state     = (stall_ctr_r <= 2'd1) ? RUN : STALL;
        end else if (stall_req) begin
            pcWriteOut    = 1'b0;
            ifidWriteOut  = 1'b0;
            idexBubbleOut = 1'b1;
            stall_inc     = 1'b1;
            if (stall_two) begin
                nxt_ctr   = 2'd1;
                nxt_state = STALL;
            end else begin
                nxt_state = RUN;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_r     <= RUN;
            saved_r     <= RUN;
            stall_ctr_r <= 2'd0;
            stallCntOut <= '0;
            flushCntOut <= '0;
        end else begin
            state_r     <= nxt_state;
            saved_r     <= nxt_saved;
            stall_ctr_r <= nxt_ctr;
            if (stall_inc) stallCntOut <= sat_inc(stallCntOut);
            if (flush_inc) flushCntOut <= sat_inc(flushCntOut);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with narrow counters so saturation is reachable.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STL   = 5'b00010;
    localparam logic [4:0] HOLD  = 5'b00001;
    localparam logic [4:0] RSTO  = 5'b00110;

    logic             clkIn = 1'b0;
    logic             resetIn;
    logic [4:0]       rs1In, rs2In, exRdIn, maRdIn;
    logic             useRs1In, useRs2In, exRegWriteIn, exMemReadIn, maRegWriteIn;
    logic             branchTakenIn, memReadyIn;
    logic             pcWriteOut, ifidWriteOut, ifidFlushOut, idexBubbleOut, pipeHoldOut;
    logic [1:0]       fwdAOut, fwdBOut, stateOut;
    logic [CNT_W-1:0] stallCntOut, flushCntOut;
    logic [4:0]       ctl;
    logic [2:0]       flush_bits;
    int               errors = 0;
    int               checks = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clkIn(clkIn), .resetIn(resetIn),
        .rs1In(rs1In), .rs2In(rs2In), .useRs1In(useRs1In), .useRs2In(useRs2In),
        .exRdIn(exRdIn), .exRegWriteIn(exRegWriteIn), .exMemReadIn(exMemReadIn),
        .maRdIn(maRdIn), .maRegWriteIn(maRegWriteIn),
        .branchTakenIn(branchTakenIn), .memReadyIn(memReadyIn),
        .pcWriteOut(pcWriteOut), .ifidWriteOut(ifidWriteOut), .ifidFlushOut(ifidFlushOut),
        .idexBubbleOut(idexBubbleOut), .pipeHoldOut(pipeHoldOut),
        .fwdAOut(fwdAOut), .fwdBOut(fwdBOut),
        .stallCntOut(stallCntOut), .flushCntOut(flushCntOut), .stateOut(stateOut)
    );

    always #5 clkIn = ~clkIn;

    assign ctl        = {pcWriteOut, ifidWriteOut, ifidFlushOut, idexBubbleOut, pipeHoldOut};
    assign flush_bits = {pcWriteOut, ifidFlushOut, idexBubbleOut};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic idle();
        rs1In = 5'd0; rs2In = 5'd0; useRs1In = 1'b0; useRs2In = 1'b0;
        exRdIn = 5'd0; exRegWriteIn = 1'b0; exMemReadIn = 1'b0;
        maRdIn = 5'd0; maRegWriteIn = 1'b0;
        branchTakenIn = 1'b0; memReadyIn = 1'b1;
    endtask

    task automatic ex_hazard();
        idle();
        exRdIn = 5'd5; exRegWriteIn = 1'b1; useRs1In = 1'b1; rs1In = 5'd5;
    endtask

    task automatic ma_hazard();
        idle();
        maRdIn = 5'd3; maRegWriteIn = 1'b1; useRs2In = 1'b1; rs2In = 5'd3;
    endtask

    initial begin
        idle();
        resetIn = 1'b1;
        #2;
        chk("reset_ctl", 16'(ctl), 16'(RSTO));
        chk("reset_fwd", 16'({fwdAOut, fwdBOut}), 16'h0);
        tick();
        tick();
        chk("reset_state", 16'(stateOut), 16'd0);
        chk("reset_stallcnt", 16'(stallCntOut), 16'd0);
        chk("reset_flushcnt", 16'(flushCntOut), 16'd0);
        resetIn = 1'b0;
        #2;
        chk("idle_ctl", 16'(ctl), 16'(NORM));
        tick();
        chk("idle_state", 16'(stateOut), 16'd0);

`ifndef HAZARD_FWD_EN
        // Two-cycle stall on an EX producer
        ex_hazard();
        #2;
        chk("ex_stall0_ctl", 16'(ctl), 16'(STL));
        chk("ex_stall0_fwd", 16'({fwdAOut, fwdBOut}), 16'h0);
        tick();
        chk("ex_stall0_state", 16'(stateOut), 16'd1);
        chk("ex_stall1_ctl", 16'(ctl), 16'(STL));
        tick();
        chk("ex_stall1_state", 16'(stateOut), 16'd0);
        chk("ex_stall_cnt", 16'(stallCntOut), 16'd2);
        idle();
        #2;
        chk("post_ex_ctl", 16'(ctl), 16'(NORM));
        tick();

        // One-cycle stall on an MA producer
        ma_hazard();
        #2;
        chk("ma_stall_ctl", 16'(ctl), 16'(STL));
        tick();
        chk("ma_stall_state", 16'(stateOut), 16'd0);
        chk("ma_stall_cnt", 16'(stallCntOut), 16'd3);
        idle();
        tick();

        // Taken branch during STALL
        ex_hazard();
        tick();
        chk("br_pre_state", 16'(stateOut), 16'd1);
        branchTakenIn = 1'b1;
        #2;
        chk("br_flush_bits", 16'(flush_bits), 16'h7);
        chk("br_hold", 16'(pipeHoldOut), 16'd0);
        tick();
        chk("br_state", 16'(stateOut), 16'd0);
        chk("br_flushcnt", 16'(flushCntOut), 16'd1);
        chk("br_stallcnt", 16'(stallCntOut), 16'd4);
        idle();
        tick();

        // Memory not ready for 3 cycles while STALL counter=1
        ex_hazard();
        tick();
        chk("mw_pre_state", 16'(stateOut), 16'd1);
        memReadyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_hold_ctl", 16'(ctl), 16'(HOLD));
            tick();
            chk("mw_hold_state", 16'(stateOut), 16'd2);
        end
        memReadyIn = 1'b1;
        #2;
        chk("mw_resume_ctl", 16'(ctl), 16'(STL));
        tick();
        chk("mw_resume_state", 16'(stateOut), 16'd0);
        chk("mw_stallcnt", 16'(stallCntOut), 16'd6);
        idle();
        #2;
        chk("mw_after_ctl", 16'(ctl), 16'(NORM));
        tick();

        // memReady low outranks a taken branch; saved RUN restored afterwards
        memReadyIn = 1'b0; branchTakenIn = 1'b1;
        #2;
        chk("mw_br_ctl", 16'(ctl), 16'(HOLD));
        tick();
        chk("mw_br_state", 16'(stateOut), 16'd2);
        chk("mw_br_flushcnt", 16'(flushCntOut), 16'd1);
        idle();
        #2;
        chk("mw_run_ctl", 16'(ctl), 16'(NORM));
        tick();
        chk("mw_run_state", 16'(stateOut), 16'd0);
`endif

        // x0 is never a hazard
        idle();
        exRdIn = 5'd0; exRegWriteIn = 1'b1; maRdIn = 5'd0; maRegWriteIn = 1'b1;
        useRs1In = 1'b1; rs1In = 5'd0; useRs2In = 1'b1; rs2In = 5'd0;
        #2;
        chk("x0_ctl", 16'(ctl), 16'(NORM));
        chk("x0_fwd", 16'({fwdAOut, fwdBOut}), 16'h0);
        tick();
        chk("x0_state", 16'(stateOut), 16'd0);

`ifdef HAZARD_FWD_EN
        // Load-use: one bubble, then WB forwarding with no stall
        idle();
        exRdIn = 5'd7; exRegWriteIn = 1'b1; exMemReadIn = 1'b1; useRs2In = 1'b1; rs2In = 5'd7;
        #2;
        chk("ld_ctl", 16'(ctl), 16'(STL));
        tick();
        chk("ld_state", 16'(stateOut), 16'd0);
        chk("ld_stallcnt", 16'(stallCntOut), 16'd1);
        exRegWriteIn = 1'b0; exMemReadIn = 1'b0; exRdIn = 5'd0;
        maRdIn = 5'd7; maRegWriteIn = 1'b1;
        #2;
        chk("ld_fwdb", 16'(fwdBOut), 16'h2);
        chk("ld_next_ctl", 16'(ctl), 16'(NORM));
        tick();
        chk("ld_next_stallcnt", 16'(stallCntOut), 16'd1);
        exRdIn = 5'd7; exRegWriteIn = 1'b1; useRs1In = 1'b1; rs1In = 5'd7;
        #2;
        chk("ex_wins_fwdb", 16'(fwdBOut), 16'h1);
        chk("ex_wins_fwda", 16'(fwdAOut), 16'h1);
        chk("ex_fwd_ctl", 16'(ctl), 16'(NORM));
        tick();
        chk("fwd_stallcnt", 16'(stallCntOut), 16'd1);
        for (int i = 0; i < 14; i++) begin
            exMemReadIn = 1'b1;
            tick();
        end
        chk("sat_stallcnt", 16'(stallCntOut), 16'd15);
        tick();
        tick();
        chk("sat_stallcnt_hold", 16'(stallCntOut), 16'd15);
        idle();
        for (int i = 0; i < 16; i++) begin
            branchTakenIn = 1'b1;
            tick();
        end
        chk("sat_flushcnt", 16'(flushCntOut), 16'd15);
        idle();
        memReadyIn = 1'b0;
        tick();
        chk("rst_mw_state", 16'(stateOut), 16'd2);
`else
        chk("x0_stallcnt", 16'(stallCntOut), 16'd6);
        // Counter saturation
        ma_hazard();
        for (int i = 0; i < 8; i++) tick();
        chk("pre_sat_stallcnt", 16'(stallCntOut), 16'd14);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_stallcnt", 16'(stallCntOut), 16'd15);
        idle();
        branchTakenIn = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("pre_sat_flushcnt", 16'(flushCntOut), 16'd14);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_flushcnt", 16'(flushCntOut), 16'd15);

        // Reset in the middle of MEMWAIT
        ex_hazard();
        tick();
        memReadyIn = 1'b0;
        tick();
        chk("rst_mw_state", 16'(stateOut), 16'd2);
`endif
        resetIn = 1'b1; branchTakenIn = 1'b1; memReadyIn = 1'b0;
        #2;
        chk("rst_mw_ctl", 16'(ctl), 16'(RSTO));
        chk("rst_mw_fwd", 16'({fwdAOut, fwdBOut}), 16'h0);
        tick();
        chk("rst_mw_state0", 16'(stateOut), 16'd0);
        chk("rst_mw_stallcnt", 16'(stallCntOut), 16'd0);
        chk("rst_mw_flushcnt", 16'(flushCntOut), 16'd0);
        resetIn = 1'b0;
        idle();
        #2;
        chk("rst_mw_run_ctl", 16'(ctl), 16'(NORM));
        tick();
        chk("rst_mw_run_state", 16'(stateOut), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-002 SHALL have port clkIn, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port resetIn, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports rs1In, rs2In, input, 5 each, source registers of the instruction in ID (from IFID).
REQ-005 SHALL have ports useRs1In, useRs2In, input, 1 each, source register actually read.
REQ-006 SHALL have ports exRdIn (5), exRegWriteIn (1), exMemReadIn (1), input, destination, write and load flags of the instruction in EX (IDEX outputs).
REQ-007 SHALL have ports maRdIn (5), maRegWriteIn (1), input, destination and write flag of the instruction in MA (EXMA outputs).
REQ-008 SHALL have ports branchTakenIn (1) and memReadyIn (1), input, taken branch/jump resolved in EX, and data memory ready.
REQ-009 SHALL have outputs pcWriteOut, ifidWriteOut, ifidFlushOut, idexBubbleOut, pipeHoldOut, 1 each; idexBubbleOut zeroes ctrSignals into IDEX; pipeHoldOut freezes IDEX and later stages.
REQ-010 SHALL have outputs fwdAOut, fwdBOut, 2 each, ALU operand forward select (00 reg, 01 EX/MA result, 10 WB result).
REQ-011 SHALL have outputs stallCntOut, flushCntOut, CNT_W each, and stateOut, 2, FSM state.

Function
REQ-012 SHALL implement states RUN=0, STALL=1, MEMWAIT=2; stateOut is the registered state.
REQ-013 SHALL define hazX (X = EX or MA) = xRegWrite && xRd!=0 && ((useRs1In && rs1In==xRd) || (useRs2In && rs2In==xRd)).
REQ-014 SHALL apply per-cycle priority: memReadyIn=0, then branchTakenIn, then data hazard, then normal.
REQ-015 SHALL drive normal outputs pcWriteOut=1, ifidWriteOut=1, ifidFlushOut=0, idexBubbleOut=0, pipeHoldOut=0.
REQ-016 SHALL drive stall outputs pcWriteOut=0, ifidWriteOut=0, idexBubbleOut=1, ifidFlushOut=0, pipeHoldOut=0.
REQ-017 SHALL, when memReadyIn=0 in any state, drive pcWriteOut=0, ifidWriteOut=0, ifidFlushOut=0, idexBubbleOut=0, pipeHoldOut=1, save current state and stall counter, and enter MEMWAIT.
REQ-018 SHALL, in MEMWAIT with memReadyIn=1, return to the saved state with counter unchanged, evaluating outputs that cycle by that state's rules.
REQ-019 SHALL, on branchTakenIn=1 (memory ready), drive pcWriteOut=1, ifidFlushOut=1, idexBubbleOut=1, clear the stall counter, go RUN, and increment flushCntOut.
REQ-020 SHALL, in RUN on a stall-requiring hazard, emit stall outputs in the detection cycle; for 2-cycle stalls load counter=1 and enter STALL; for 1-cycle stalls stay RUN.
REQ-021 SHALL, in STALL, emit stall outputs, ignore hazard detection, decrement counter, return to RUN when counter reaches 0.
REQ-022 SHALL increment stallCntOut once per cycle with stall outputs from a data hazard; both counters saturate at all ones.

Reset
REQ-023 SHALL, on posedge with resetIn=1, set state RUN, stall counter 0, saved state RUN, stallCntOut=0, flushCntOut=0.
REQ-024 SHALL, while resetIn=1, force pcWriteOut=0, ifidWriteOut=0, ifidFlushOut=1, idexBubbleOut=1, pipeHoldOut=0, fwdAOut=fwdBOut=00.
REQ-025 SHALL give reset priority over memReadyIn and branchTakenIn, including mid-STALL or mid-MEMWAIT.

Configuration
REQ-026 SHALL compile forwarding in only with macro HAZARD_FWD_EN defined.
REQ-027 SHALL, with HAZARD_FWD_EN, stall 1 cycle only when hazEX && exMemReadIn; fwd select 01 on EX match (non-load), else 10 on MA match, else 00; EX wins over MA.
REQ-028 SHALL, without HAZARD_FWD_EN, tie fwdAOut=fwdBOut=00, stall 2 cycles on hazEX, else 1 cycle on hazMA.

Verification
REQ-029 SHALL cover: no FWD, exRd=5 regWrite, rs1=5 used -> 2 cycles of pcWrite=0/idexBubble=1, state 0->1->0, stallCnt=2.
REQ-030 SHALL cover: FWD, EX load rd=7, rs2=7 -> 1 bubble cycle; next cycle maRd=7 -> fwdB=10, no stall.
REQ-031 SHALL cover: branchTaken=1 during STALL -> ifidFlush=1, idexBubble=1, state RUN, flushCnt=1.
REQ-032 SHALL cover: memReady=0 for 3 cycles during STALL counter=1 -> pipeHold=1, state 2; on ready returns STALL, 1 more stall cycle.
REQ-033 SHALL cover: rd=0 with regWrite and rs1=0 -> no stall, fwd 00; counters preset near max saturate at all ones.
REQ-034 SHALL cover: resetIn=1 mid-MEMWAIT -> next cycle state 0, counters 0, reset outputs per REQ-024.
